// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed seven-segment scan controller
//
// Shares one external hex-to-seven-segment decoder across NUM_DIGITS digits.
// Each slot is CLK_DIV cycles long and starts with BLANK_CYCLES of dark anodes
// to avoid ghosting. Value updates are double-buffered and only become visible
// at a frame boundary.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_value        4*NUM_DIGITS hex value, digit 0 in the low nibble
//   i_load         strobe capturing i_value/i_dp/i_blank into the pending register
//   i_dp           decimal point per digit, 1 = lit
//   i_blank        force-blank per digit, 1 = dark
//   i_lz_en        leading-zero suppression enable, sampled at slot start
//   o_nibble       nibble presented to the external decoder
//   i_seg          active-high segment pattern returned by the decoder
//   o_seg, o_dp    registered segment / decimal-point drive
//   o_anode        registered anode drive, one active digit at a time
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 1000,
    parameter int BLANK_CYCLES     = 1,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_load,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_lz_en,
    output logic [3:0]              o_nibble,
    input  logic [6:0]              i_seg,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_anode
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST       = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

    // Inactive output levels; also used as XOR masks to apply polarity.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    lz_q;
    logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, disp_blank;

    logic                    slot_end, frame_end;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run, dp_run;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_dark;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot counter, digit index, double-buffered display data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt        <= '0;
            idx        <= '0;
            lz_q       <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Count 0 always lies inside the blanking guard, so the sampled
            // enable is in place before any drive decision of this slot.
            if (cnt == '0) begin
                lz_q <= i_lz_en;
            end
            if (i_load) begin
                pend_value <= i_value;
                pend_dp    <= i_dp;
                pend_blank <= i_blank;
            end
            // A load coinciding with the frame boundary bypasses pending so it
            // is not delayed by a whole frame.
            if (frame_end) begin
                disp_value <= i_load ? i_value : pend_value;
                disp_dp    <= i_load ? i_dp    : pend_dp;
                disp_blank <= i_load ? i_blank : pend_blank;
            end
        end
    end

    // Leading-zero suppression: walk from the most significant digit down;
    // a digit is suppressed while every nibble from it upward is zero and no
    // decimal point has been seen yet. Digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        dp_run   = 1'b0;
        supp     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_value[4*k +: 4] == 4'h0);
            dp_run   = dp_run || disp_dp[k];
            supp[k]  = lz_q && (k != 0) && zero_run && !dp_run;
        end
    end

    // Current-digit selection.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_dark  = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib      = disp_value[4*k +: 4];
                cur_dp       = disp_dp[k];
                cur_dark     = disp_blank[k] || supp[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

    assign o_nibble = cur_nib;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BLANK: if (cnt == CNT_BLANK_LAST) state_nxt = S_DRIVE;
            S_DRIVE: if (slot_end)              state_nxt = S_BLANK;
            default:                            state_nxt = S_BLANK;
        endcase
    end

    // FSM output logic: next value of the drive registers.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (state == S_DRIVE && !cur_dark) begin
            seg_d = i_seg ^ SEG_OFF;
            dp_d  = cur_dp ^ DP_OFF;
            an_d  = an_onehot ^ AN_OFF;
        end
    end

    // Drive registers; lag the FSM by one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_seg   <= SEG_OFF;
            o_dp    <= DP_OFF;
            o_anode <= AN_OFF;
        end else begin
            o_seg   <= seg_d;
            o_dp    <= dp_d;
            o_anode <= an_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard testbench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  nibble;
    logic [6:0]  seg_in;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  anode;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4),
        .CLK_DIV(8),
        .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_value(value),
        .i_load(load),
        .i_dp(dp),
        .i_blank(blank),
        .i_lz_en(lz_en),
        .o_nibble(nibble),
        .i_seg(seg_in),
        .o_seg(seg),
        .o_dp(dp_out),
        .o_anode(anode)
    );

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    assign seg_in = hex7(nibble);

    // Free-running cycle count since reset release; interval n is the time
    // between posedge n and n+1, during which the scan count is n % 8.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic push_lit(input int slot, input logic [6:0] s, input logic d);
        exp_t e;
        logic [3:0] one = 4'b0001;
        e.slot = slot;
        e.an   = ~(one << (slot % 4));
        e.seg  = s;
        e.dp   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_dark(input int slot);
        exp_t e;
        e.slot = slot;
        e.an   = 4'b1111;
        e.seg  = 7'h00;
        e.dp   = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_int(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    task automatic load_at(input int n, input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] b);
        wait_int(n);
        value = v;
        dp    = d;
        blank = b;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Monitor: slot s owns intervals 8s+1..8s+8; the first two must be dark
    // (blank guard plus register lag), the last six carry the slot's digit.
    exp_t cur;
    bit   act = 0;
    bit   slot_bad;
    always @(negedge clk) begin
        if (rst) begin
            act = 0;
        end else if (cyc >= 1) begin
            int s, pos;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            s   = (cyc - 1) / 8;
            pos = (cyc - 1) % 8;
            if (pos == 0) begin
                act      = 0;
                slot_bad = 0;
                if (exp_q.size() > 0 && exp_q[0].slot == s) begin
                    cur = exp_q.pop_front();
                    act = 1;
                end
            end
            if (act) begin
                if (pos < 2) begin
                    e_an = 4'b1111; e_seg = 7'h00; e_dp = 1'b0;
                end else begin
                    e_an = cur.an; e_seg = cur.seg; e_dp = cur.dp;
                end
                if (!slot_bad && (anode !== e_an || seg !== e_seg || dp_out !== e_dp)) begin
                    $display("FAIL slot%0d pos%0d: anode=%b seg=%h dp=%b, expected anode=%b seg=%h dp=%b",
                             s, pos, anode, seg, dp_out, e_an, e_seg, e_dp);
                    slot_bad = 1;
                end
                if (pos == 7) begin
                    checks++;
                    if (slot_bad) errors++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp = '0; blank = '0; lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (anode !== 4'b1111 || seg !== 7'h00 || dp_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: anode=%b seg=%h dp=%b, expected 1111 00 0", anode, seg, dp_out);
        end
        checks++;
        if (nibble !== 4'h0) begin
            errors++;
            $display("FAIL reset_nibble: got %h expected 0", nibble);
        end

        // Frame 0 shows the cleared display: all zeros, no suppression.
        for (int i = 0; i < 4; i++) push_lit(i, 7'h3F, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic scan of 12AF in frame 1.
        load_at(0, 16'h12AF, 4'b0000, 4'b0000);
        push_lit(4, 7'h71, 1'b0);
        push_lit(5, 7'h77, 1'b0);
        push_lit(6, 7'h5B, 1'b0);
        push_lit(7, 7'h06, 1'b0);

        // Leading-zero suppression of 0030.
        wait_int(40);
        lz_en = 1'b1;
        load_at(40, 16'h0030, 4'b0000, 4'b0000);
        push_lit(8, 7'h3F, 1'b0);
        push_lit(9, 7'h4F, 1'b0);
        push_dark(10);
        push_dark(11);

        // Decimal point on digit 2 cancels its suppression.
        load_at(72, 16'h0030, 4'b0100, 4'b0000);
        push_lit(12, 7'h3F, 1'b0);
        push_lit(13, 7'h4F, 1'b0);
        push_lit(14, 7'h3F, 1'b1);
        push_dark(15);

        // Display 1234 in frame 4, then a mid-frame load during digit 1.
        load_at(104, 16'h1234, 4'b0000, 4'b0000);
        wait_int(128);
        lz_en = 1'b0;
        push_lit(16, 7'h66, 1'b0);
        push_lit(17, 7'h4F, 1'b0);
        push_lit(18, 7'h5B, 1'b0);
        push_lit(19, 7'h06, 1'b0);
        load_at(138, 16'hFFFF, 4'b0000, 4'b0000);
        for (int i = 20; i < 24; i++) push_lit(i, 7'h71, 1'b0);

        // Load exactly on the frame-boundary cycle (digit 3, count 7).
        load_at(191, 16'h8888, 4'b0000, 4'b0000);
        for (int i = 24; i < 28; i++) push_lit(i, 7'h7F, 1'b0);

        // Blank mask.
        load_at(200, 16'hAAAA, 4'b0000, 4'b0101);
        push_dark(28);
        push_lit(29, 7'h77, 1'b0);
        push_dark(30);
        push_lit(31, 7'h77, 1'b0);

        // Two loads in one frame: the second wins.
        load_at(232, 16'h5555, 4'b0000, 4'b0000);
        load_at(236, 16'h6666, 4'b0000, 4'b0000);
        push_lit(32, 7'h7D, 1'b0);
        push_lit(33, 7'h7D, 1'b0);

        // Asynchronous reset in the middle of digit 2's drive window.
        wait_int(276);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (anode !== 4'b1111 || seg !== 7'h00 || dp_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: anode=%b seg=%h dp=%b, expected 1111 00 0", anode, seg, dp_out);
        end
        value = '0; dp = '0; blank = '0;
        for (int i = 0; i < 4; i++) push_lit(i, 7'h3F, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait_int(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected slots not observed, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
